// File: rtl/dmem_mmio_bridge.sv
// Data-memory / MMIO bridge behind the core's memory stage.
// Local word RAM plus a drop-on-full store FIFO toward the peripheral bus.
module dmem_mmio_bridge #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        bus_valid,
  output logic [15:0] bus_addr,
  output logic [31:0] bus_data,
  input  logic        bus_ready,
  output logic        ovf
);

  localparam int IW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] STATUS_OFF = 16'hFFFC;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic          isMmio;
  logic          isStatus;
  logic [15:0]   offset;
  logic [IW-1:0] ramIdx;

  assign isMmio   = aluout >= MMIO_BASE;
  assign offset   = aluout[15:0];
  assign isStatus = isMmio && (offset == STATUS_OFF);
  assign ramIdx   = aluout[IW+1:2];

  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (memwrite && !isMmio) begin
      ram[ramIdx] <= writedata;
    end
  end

  logic [15:0]   qAddr [FIFO_DEPTH];
  logic [31:0]   qData [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          pushReq;
  logic          push;
  logic          drop;
  logic          ovfClr;

  assign full    = count == DEPTH_C;
  assign empty   = count == '0;
  assign pop     = bus_valid && bus_ready;
  assign pushReq = memwrite && isMmio && !isStatus;
  // a pop in the same cycle frees the slot the push needs
  assign push    = pushReq && (!full || pop);
  assign drop    = pushReq && !push;
  assign ovfClr  = memwrite && isStatus && writedata[0];

  always_ff @(posedge clk) begin
    if (push) begin
      qAddr[tail] <= offset;
      qData[tail] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovfClr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus_valid = !empty;
  assign bus_addr  = empty ? 16'h0 : qAddr[head];
  assign bus_data  = empty ? 32'h0 : qData[head];

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      !isMmio:  readdata = ram[ramIdx];
      isStatus: readdata = {ovf, full, empty, 21'b0, 8'(count)};
      default:  readdata = '0;
    endcase
  end

endmodule
